// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_if : fetch/data request channels plus the byte-wide mem bus
// Rev 1.0
// ============================================================================
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_done;
  logic [31:0] if_data;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_grant;
  logic        d_done;
  logic [31:0] d_rdata;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // master: requesters and memory/IO side; slave: the arbiter itself
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_din, io_buffer_full,
    input  if_grant, if_done, if_data, d_grant, d_done, d_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_din, io_buffer_full,
    output if_grant, if_done, if_data, d_grant, d_done, d_rdata, mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : arbitrates fetch/data requests onto a byte-wide memory bus
// Rev 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  wire              clk_in,
  input  wire              rst_in,
  input  wire              rdy_in,
  input  wire              flush,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;     // 1 when the previous grant went to data
  logic        fetch_q, fetch_d;
  logic        we_q, we_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        wr_q, wr_d;
  logic        if_grant_q, if_grant_d;
  logic        d_grant_q, d_grant_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic [2:0]  cnt_nx;
  logic [1:0]  cap_idx;
  logic        d_ok;
  logic        pick_d;

  assign cnt_nx  = cnt_q + 3'd1;
  assign cap_idx = 2'(cnt_q - 3'd1);
  assign d_ok    = bus.d_req & ~(bus.d_we & (bus.d_addr[17:16] == IO_SEL) & bus.io_buffer_full);
  assign pick_d  = d_ok & (~bus.if_req | ~last_d_q);

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    fetch_d    = fetch_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;
    mem_a_d    = 32'd0;
    mem_dout_d = 8'd0;
    wr_d       = 1'b0;
    if_grant_d = 1'b0;
    d_grant_d  = 1'b0;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (pick_d) begin
            d_grant_d = 1'b1;
            last_d_d  = 1'b1;
            fetch_d   = 1'b0;
            we_d      = bus.d_we;
            base_d    = bus.d_addr;
            wdata_d   = bus.d_wdata;
            len_d     = (bus.d_size == 2'd0) ? 3'd1 : (bus.d_size == 2'd1) ? 3'd2 : 3'd4;
            cnt_d     = 3'd0;
            rbuf_d    = 32'd0;
            mem_a_d   = bus.d_addr;
            if (bus.d_we) begin
              mem_dout_d = bus.d_wdata[7:0];
              wr_d       = 1'b1;
              state_d    = S_WR;
            end else begin
              state_d = S_RD;
            end
          end else if (bus.if_req) begin
            if_grant_d = 1'b1;
            last_d_d   = 1'b0;
            fetch_d    = 1'b1;
            we_d       = 1'b0;
            base_d     = bus.if_addr;
            len_d      = 3'd4;
            cnt_d      = 3'd0;
            rbuf_d     = 32'd0;
            mem_a_d    = bus.if_addr;
            state_d    = S_RD;
          end
        end
      end

      S_RD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_nx;
          // memory answers two edges after the address goes out
          if (cnt_q != 3'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt_nx < len_q) mem_a_d = base_q + {29'd0, cnt_nx};
          if (cnt_q == len_q) begin
            state_d = S_IDLE;
            if (fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end else begin
              d_done_d  = 1'b1;
              d_rdata_d = rbuf_d;
            end
          end
        end
      end

      S_WR: begin
        if (cnt_nx < len_q) begin
          cnt_d      = cnt_nx;
          mem_a_d    = base_q + {29'd0, cnt_nx};
          mem_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
          wr_d       = 1'b1;
        end else begin
          state_d  = S_IDLE;
          d_done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      last_d_q   <= 1'b0;
      fetch_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      wr_q       <= 1'b0;
      if_grant_q <= 1'b0;
      d_grant_q  <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_data_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      fetch_q    <= fetch_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
      if_grant_q <= if_grant_d;
      d_grant_q  <= d_grant_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // gating with rdy_in keeps a frozen write byte from being committed twice
  assign bus.mem_wr   = wr_q & rdy_in;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.if_grant = if_grant_q;
  assign bus.d_grant  = d_grant_q;
  assign bus.if_done  = if_done_q;
  assign bus.d_done   = d_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : directed + randomized bench with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush;

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.IO_SEL(2'b11)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory: environment copy (driven by DUT) and model copy
  logic [7:0] env_mem   [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];
  int env_wr_total = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    env_mem[a]   = v;
    model_mem[a] = v;
  endtask

  // one-cycle-latency memory that, like the rest of the system, stalls with rdy_in
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (bus.mem_wr === 1'b1) begin
        env_mem[bus.mem_a] = bus.mem_dout;
        env_wr_total++;
      end
      bus.mem_din <= env_rd(bus.mem_a);
    end
  end

  // ---------------- transaction-level reference model
  bit          m_busy = 0, m_fetch = 0, m_we = 0, m_last_d = 0;
  logic [31:0] m_base = 0, m_wdata = 0;
  int          m_n = 0, m_t = 0;   // m_t = edges elapsed since the grant edge
  logic        e_ifg = 0, e_dg = 0, e_ifd = 0, e_dd = 0;
  logic [31:0] e_ifdata = 0, e_drdata = 0;

  task automatic model_edge();
    bit d_ok, pick_d;
    logic [31:0] data;
    if (rdy_in && m_busy && m_we && m_t < m_n)
      model_mem[m_base + 32'(m_t)] = m_wdata[8*m_t +: 8];
    if (!rst_in) begin
      m_busy = 0; m_last_d = 0;
      e_ifg = 0; e_dg = 0; e_ifd = 0; e_dd = 0;
      e_ifdata = 0; e_drdata = 0;
    end else if (rdy_in) begin
      e_ifg = 0; e_dg = 0; e_ifd = 0; e_dd = 0;
      if (m_busy) begin
        if (m_we) begin
          m_t++;
          if (m_t == m_n) begin m_busy = 0; e_dd = 1; end
        end else if (flush) begin
          m_busy = 0;
        end else begin
          m_t++;
          if (m_t == m_n + 1) begin
            data = 0;
            for (int k = 0; k < m_n; k++) data[8*k +: 8] = model_rd(m_base + 32'(k));
            if (m_fetch) begin e_ifd = 1; e_ifdata = data; end
            else         begin e_dd  = 1; e_drdata = data; end
            m_busy = 0;
          end
        end
      end else if (!flush) begin
        d_ok = bus.d_req && !(bus.d_we && bus.d_addr[17:16] == 2'b11 && bus.io_buffer_full);
        if (d_ok && bus.if_req) pick_d = !m_last_d;
        else                    pick_d = d_ok;
        if (pick_d) begin
          m_busy = 1; m_fetch = 0; m_we = bus.d_we; m_base = bus.d_addr;
          m_wdata = bus.d_wdata; m_t = 0; m_last_d = 1; e_dg = 1;
          m_n = (bus.d_size == 0) ? 1 : (bus.d_size == 1) ? 2 : 4;
        end else if (bus.if_req) begin
          m_busy = 1; m_fetch = 1; m_we = 0; m_base = bus.if_addr;
          m_t = 0; m_n = 4; m_last_d = 0; e_ifg = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea;
    logic [7:0]  ed;
    logic        ew;
    ea = 0; ed = 0; ew = 0;
    if (m_busy && m_t < m_n) begin
      ea = m_base + 32'(m_t);
      if (m_we) begin ed = m_wdata[8*m_t +: 8]; ew = rdy_in; end
    end
    check_eq("bus{a,dout,wr}", {bus.mem_a, bus.mem_dout, bus.mem_wr}, {ea, ed, ew});
    check_eq("pulses{ifg,ifd,dg,dd}", {bus.if_grant, bus.if_done, bus.d_grant, bus.d_done},
             {e_ifg, e_ifd, e_dg, e_dd});
    check_eq("if_data", bus.if_data, e_ifdata);
    check_eq("d_rdata", bus.d_rdata, e_drdata);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic quiet_inputs();
    bus.if_req = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
    bus.io_buffer_full = 0; flush = 0; rdy_in = 1;
  endtask

  task automatic drain();
    quiet_inputs();
    repeat (8) cycle();
  endtask

  task automatic run_to_done(input bit fetch, output int lat, output int wrs);
    lat = 0; wrs = 0;
    for (int k = 1; k <= 16 && lat == 0; k++) begin
      cycle();
      if (bus.mem_wr === 1'b1) wrs++;
      if ((fetch ? bus.if_done : bus.d_done) === 1'b1) lat = k;
    end
    check_eq(fetch ? "if_done_seen" : "d_done_seen", 64'(lat != 0), 64'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0100;
      1: return 32'h0001_FFFE;
      2: return 32'h0001_FFFF;
      3: return 32'h0003_0000;
      4: return 32'h0003_0001;
      5: return 32'hFFFF_FFFE;
      6: return 32'hFFFF_FFFF;
      default: return 32'h0000_2000 + $urandom_range(0, 63);
    endcase
  endfunction

  initial begin
    int lat, wrs, w0, cnt;
    logic [3:0] seq;

    rst_in = 0; bus.if_addr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    quiet_inputs();
    repeat (3) cycle();
    rst_in = 1;
    cycle();
    check_eq("reset_outputs", {bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_grant,
             bus.if_done, bus.d_grant, bus.d_done}, 64'd0);
    check_eq("reset_data", {bus.if_data, bus.d_rdata}, 64'd0);

    // word fetch from 0x100
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    bus.if_req = 1; bus.if_addr = 32'h100;
    cycle();
    check_eq("fetch_grant", bus.if_grant, 1);
    run_to_done(1'b1, lat, wrs);
    bus.if_req = 0;
    check_eq("fetch_latency", lat, 5);
    check_eq("fetch_data", bus.if_data, 32'h0010_0513);
    drain();

    // simultaneous requests right after reset: D,F,D,F
    rst_in = 0; cycle(); rst_in = 1;
    preload(32'h2000, 8'hF5);
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 32'h2000;
    seq = 0; cnt = 0;
    for (int k = 0; k < 40 && cnt < 4; k++) begin
      cycle();
      if (bus.d_grant === 1'b1 || bus.if_grant === 1'b1) begin
        seq = {seq[2:0], bus.d_grant === 1'b1};
        cnt++;
      end
      if (bus.d_done === 1'b1) check_eq("byte_load", bus.d_rdata, 32'h0000_00F5);
    end
    check_eq("grant_order", seq, 4'b1010);
    drain();

    // half store across the 0x1FFFF/0x20000 boundary
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 1;
    bus.d_addr = 32'h0001_FFFF; bus.d_wdata = 32'hAABB_CCDD;
    cycle();
    check_eq("store_grant", bus.d_grant, 1);
    w0 = (bus.mem_wr === 1'b1) ? 1 : 0;
    bus.d_req = 0;
    run_to_done(1'b0, lat, wrs);
    check_eq("store_wr_cycles", w0 + wrs, 2);
    check_eq("store_byte0", env_rd(32'h0001_FFFF), 8'hDD);
    check_eq("store_byte1", env_rd(32'h0002_0000), 8'hCC);
    drain();

    // IO store held off by a full buffer
    bus.io_buffer_full = 1;
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 0;
    bus.d_addr = 32'h0003_0000; bus.d_wdata = 32'h0000_0041;
    repeat (3) begin cycle(); check_eq("io_no_grant", bus.d_grant, 0); end
    bus.io_buffer_full = 0;
    w0 = env_wr_total;
    cycle();
    check_eq("io_grant", bus.d_grant, 1);
    bus.d_req = 0;
    run_to_done(1'b0, lat, wrs);
    check_eq("io_write_count", env_wr_total - w0, 1);
    check_eq("io_write_value", env_rd(32'h0003_0000), 8'h41);
    drain();

    // flush after byte 1 of a fetch, then a fresh fetch
    bus.if_req = 1; bus.if_addr = 32'h400;
    cycle();
    check_eq("flush_fetch_grant", bus.if_grant, 1);
    bus.if_req = 0;
    cycle();
    flush = 1;
    cycle();
    check_eq("flush_bus_idle", {bus.mem_a, bus.mem_wr}, 64'd0);
    bus.if_req = 1; bus.if_addr = 32'h500;
    cycle();
    check_eq("flush_blocks_grant", bus.if_grant, 0);
    flush = 0;
    cycle();
    check_eq("post_flush_grant", bus.if_grant, 1);
    bus.if_req = 0;
    run_to_done(1'b1, lat, wrs);
    drain();

    // flush held across a word store: all bytes still go out
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 2;
    bus.d_addr = 32'h600; bus.d_wdata = 32'h1122_3344;
    w0 = env_wr_total;
    cycle();
    bus.d_req = 0; flush = 1;
    run_to_done(1'b0, lat, wrs);
    check_eq("flush_store_writes", env_wr_total - w0, 4);
    check_eq("flush_store_byte3", env_rd(32'h603), 8'h11);
    drain();

    // rdy_in low mid-store: frozen byte written exactly once
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 3;
    bus.d_addr = 32'h700; bus.d_wdata = 32'hCAFE_F00D;
    w0 = env_wr_total;
    cycle();
    bus.d_req = 0;
    cycle();
    rdy_in = 0; cycle(); cycle();
    rdy_in = 1;
    run_to_done(1'b0, lat, wrs);
    check_eq("stall_store_writes", env_wr_total - w0, 4);
    check_eq("stall_store_byte1", env_rd(32'h701), 8'hF0);

    // reset mid-fetch abandons it silently
    bus.if_req = 1; bus.if_addr = 32'h800;
    cycle();
    bus.if_req = 0;
    cycle(); cycle();
    rst_in = 0;
    cycle();
    check_eq("midreset_outputs", {bus.mem_a, bus.mem_dout, bus.mem_wr, bus.if_grant,
             bus.if_done, bus.d_grant, bus.d_done}, 64'd0);
    check_eq("midreset_data", {bus.if_data, bus.d_rdata}, 64'd0);
    rst_in = 1;
    cnt = 0;
    repeat (8) begin cycle(); if (bus.if_done === 1'b1) cnt++; end
    check_eq("midreset_no_done", cnt, 0);

    // randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst_in             = ($urandom_range(0, 199) != 0);
      rdy_in             = ($urandom_range(0, 7) != 0);
      flush              = ($urandom_range(0, 11) == 0);
      bus.io_buffer_full = $urandom_range(0, 1);
      bus.if_req         = ($urandom_range(0, 3) != 0);
      bus.if_addr        = rand_addr();
      bus.d_req          = ($urandom_range(0, 3) != 0);
      bus.d_we           = $urandom_range(0, 1);
      bus.d_size         = 2'($urandom_range(0, 3));
      bus.d_addr         = rand_addr();
      bus.d_wdata        = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the single byte-wide memory/IO bus.
- Arbitrates between two requesters: instruction fetch (always 32-bit reads) and data access (1/2/4-byte loads and stores).
- Sequences each granted request into per-byte bus cycles, assembles little-endian read data, and returns a one-cycle done pulse.
- Sits between the fetch/issue logic and the load/store path on one side and the cpu top-level mem_* pins on the other.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global enable; low freezes all state
- flush  in  1  pipeline flush
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_grant  out  1  one-cycle pulse: fetch request accepted
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 or 3 = word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; low bytes used
- d_grant  out  1  one-cycle pulse: data request accepted
- d_done  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  32  load data, zero-extended; sign extension is done by the consumer
- mem_din  in  8  memory read byte
- mem_dout  out  8  memory write byte
- mem_a  out  32  memory address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (rst_in == 0 at clk edge):
  - state = IDLE, last_grant = FETCH.
  - All outputs 0.
  - Reset mid-transfer abandons the transfer; no done is issued.
- rdy_in low:
  - No state, counter or output register changes.
  - mem_wr is driven as wr_reg & rdy_in, so a frozen write byte is not repeated; it is written once rdy_in returns.
- States: IDLE, RD, WR. Byte counter cnt is 3 bits; length N = 1, 2 or 4 (fetch N = 4).
- IDLE arbitration, evaluated at each enabled edge with flush == 0:
  - Candidates: if_req, and d_req.
  - d_req is ineligible when d_we == 1, d_addr[17:16] == IO_SEL and io_buffer_full == 1.
  - If both are eligible, grant the one NOT equal to last_grant. If one is eligible, grant it.
  - On grant at edge E0: pulse the matching *_grant, latch addr/size/we/wdata, set last_grant, cnt = 0.
  - Next state: RD for fetches and loads, WR for stores.
- RD, byte i (i = 0..N-1):
  - mem_a = base + i is presented after edge E0+i, with mem_wr = 0.
  - mem_din for byte i is captured at edge E0+i+2 into bits [8i+7:8i].
  - After edge E0+N+1: *_done = 1 for one cycle, data output valid, unused upper bytes 0, state = IDLE.
  - A word read therefore completes 5 cycles after the grant edge. The earliest next grant is edge E0+N+2.
- WR, byte i:
  - After edge E0+i: mem_a = base + i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - After edge E0+N: d_done pulses, bus goes idle, state = IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check.
- Idle bus, meaning any cycle without a byte being presented: mem_a = 0, mem_dout = 0, mem_wr = 0.
- Data outputs hold their last value between done pulses.
- Flush:
  - While flush == 1, IDLE grants nothing.
  - A flush during RD (fetch or load) returns to IDLE at that edge. No done is issued, and the bus is idle next cycle.
  - A flush during WR is ignored; the store completes and d_done still pulses.
- A request dropped before grant is simply not served.
- Request inputs are ignored outside IDLE.

Test Plan:
- Word fetch: if_addr = 0x100, mem bytes 0x13,0x05,0x10,0x00 → if_grant at E0; mem_a 0x100..0x103 on consecutive cycles; if_done after E0+5 with if_data = 0x00100513.
- Simultaneous if_req and d_req (load, size 0, addr 0x2000, byte 0xF5) right after reset → data granted first, d_rdata = 0x000000F5; fetch granted at the next IDLE edge. Both held continuously → grants alternate D,F,D,F.
- Store half: d_addr = 0x1FFFF, d_wdata = 0xAABBCCDD → writes 0xDD@0x1FFFF, then 0xCC@0x20000, mem_wr high exactly 2 cycles, then d_done.
- IO store of 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles → no grant while full; grant on the first edge after it drops; single write of 0x41 to 0x30000.
- Flush after byte 1 of a fetch → no if_done, bus idle next cycle, new fetch grantable after flush deasserts. Flush during a word store → all 4 bytes still written and d_done pulses.
- rdy_in low for 2 cycles mid-store, then rst_in low mid-fetch → the frozen write byte is written exactly once after resume; on reset all outputs go 0 and no done is issued.
